// File: rtl/dp_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dp_sequencer_if : instruction handshake and datapath control bundle       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface dp_sequencer_if;
  logic       start;
  logic [2:0] opcode;
  logic [1:0] rd;
  logic [1:0] rs;
  logic [2:0] sr;
  logic [1:0] Rn;
  logic       w;
  logic [1:0] aluop;
  logic       lt;
  logic [2:0] tsel;
  logic [2:0] bsel;
  logic       busy;
  logic       done;

  modport master (
    output start, opcode, rd, rs,
    input  sr, Rn, w, aluop, lt, tsel, bsel, busy, done
  );

  modport slave (
    input  start, opcode, rd, rs,
    output sr, Rn, w, aluop, lt, tsel, bsel, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/dp_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dp_sequencer : multi-cycle controller for the R0..R3 / tmp / ALU datapath |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module dp_sequencer #(
  parameter int ALU_LAT = 1
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  dp_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_TLD   = 3'd1,
    S_EXEC  = 3'd2,
    S_WB_IN = 3'd3,
    S_WB_T  = 3'd4,
    S_WB_A  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [2:0] C_OP_LOAD  = 3'b000;
  localparam logic [2:0] C_OP_MOV   = 3'b001;
  localparam logic [2:0] C_OP_TMPB  = 3'b101;
  localparam logic [2:0] C_OP_TMPR0 = 3'b110;
  localparam logic [2:0] C_OP_ACC   = 3'b111;
  localparam logic [1:0] C_LAST_CNT = 2'(ALU_LAT - 1);

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [2:0] op_q, op_d;
  logic [1:0] rd_q, rd_d;
  logic [1:0] rs_q, rs_d;

  logic [1:0] w_aluop;
  logic [2:0] w_bsel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      rs_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rs_q    <= rs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rd_d    = rd_q;
    rs_d    = rs_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d  = bus.opcode;
          rd_d  = bus.rd;
          rs_d  = bus.rs;
          cnt_d = '0;
          case (bus.opcode)
            C_OP_LOAD:                        state_d = S_WB_IN;
            C_OP_MOV, C_OP_TMPB, C_OP_TMPR0:  state_d = S_TLD;
            default:                          state_d = S_EXEC;
          endcase
        end
      end
      S_TLD:   state_d = (op_q == C_OP_MOV) ? S_WB_T : S_DONE;
      S_EXEC: begin
        // ACC feeds the ALU result back into tmp instead of a register
        if (cnt_q == C_LAST_CNT) begin
          state_d = (op_q == C_OP_ACC) ? S_TLD : S_WB_A;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_WB_IN, S_WB_T, S_WB_A: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // XOR/AND/SHL map to opcode-2; ACC reuses XOR
  assign w_aluop = (op_q == C_OP_ACC) ? 2'b00 : (op_q[1:0] - 2'b10);

  always_comb begin
    case (rs_q)
      2'b01:   w_bsel = 3'b001;
      2'b10:   w_bsel = 3'b010;
      2'b11:   w_bsel = 3'b100;
      default: w_bsel = 3'b000;
    endcase
  end

  always_comb begin
    bus.sr    = '0;
    bus.Rn    = '0;
    bus.w     = 1'b0;
    bus.aluop = '0;
    bus.lt    = 1'b0;
    bus.tsel  = '0;
    bus.bsel  = '0;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    if (state_q != S_IDLE) begin
      bus.busy = 1'b1;
      bus.Rn   = rd_q;
      bus.bsel = w_bsel;
    end
    case (state_q)
      S_WB_IN: begin
        bus.sr = 3'b001;
        bus.w  = 1'b1;
      end
      S_TLD: begin
        bus.lt = 1'b1;
        case (op_q)
          C_OP_MOV, C_OP_TMPB: bus.tsel = 3'b100;
          C_OP_TMPR0:          bus.tsel = 3'b010;
          default:             bus.tsel = 3'b001;
        endcase
      end
      S_EXEC:  bus.aluop = w_aluop;
      S_WB_T: begin
        bus.sr = 3'b100;
        bus.w  = 1'b1;
      end
      S_WB_A: begin
        bus.sr    = 3'b010;
        bus.w     = 1'b1;
        bus.aluop = w_aluop;
      end
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/dp_sequencer.md
Name: dp_sequencer

Overview:
- Multi-cycle controller for the 4-register / tmp / ALU datapath (R0..R3, tmp, registered ALU, R0 on `out`).
- Accepts one 3-bit instruction per start handshake and drives the datapath controls cycle by cycle: sr, Rn, w, aluop, lt, tsel, bsel.
- Reports completion with a one-cycle done pulse.
- Sits between the lab top-level stimulus (switches/testbench) and the datapath.

Parameters:
- ALU_LAT, 1, number of EXEC cycles held before the ALU result is consumed. Legal range 1..3, because the datapath ALU output is registered.

Ports:
- clk  input  1  clock, all state updates on posedge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- opcode  input  3  instruction, latched on accept
- rd  input  2  destination register index, latched on accept
- rs  input  2  B-operand select, latched on accept: 00 = none (operand 0), 01 = R1, 10 = R2, 11 = R3
- sr  output  3  one-hot writeback source: 001 = in, 010 = alu_out, 100 = tmp
- Rn  output  2  write register index
- w  output  1  register write enable
- aluop  output  2  00 = XOR, 01 = AND, 10 = tmp<<1, 11 = pass B
- lt  output  1  tmp load enable
- tsel  output  3  one-hot tmp source: 001 = alu_out, 010 = out (R0), 100 = Bin
- bsel  output  3  one-hot B select: 001 = R1, 010 = R2, 100 = R3, 000 = zero
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse in DONE

Behaviour:
- Reset (async, rst_n low): state = IDLE, exec counter = 0, latched fields = 0.
  - All outputs 0: sr, Rn, w, aluop, lt, tsel, bsel, busy, done.
  - Reset mid-instruction aborts immediately. No w or lt may assert in the cycle after rst_n rises.
- Outputs are a Moore decode of the state plus the latched opcode/rd/rs. Outputs not listed for a state are 0.
- bsel = onehot(rs_latched) in every non-IDLE state; 000 when rs = 00.
- Rn = rd_latched in every non-IDLE state.
- States: IDLE, TLD, EXEC, WB_IN, WB_T, WB_A, DONE.
- IDLE: on posedge with start = 1, latch opcode/rd/rs and go to the first state of the opcode. start = 0 stays in IDLE.
- Opcode sequences (cycles counted from the accept edge):
  - 000 LOAD, R[rd] <= in: WB_IN (sr = 001, w = 1) -> DONE. 2 cycles.
  - 001 MOV, R[rd] <= R[rs]: TLD (lt = 1, tsel = 100) -> WB_T (sr = 100, w = 1) -> DONE. 3 cycles.
  - 010 XOR, 011 AND, 100 SHL, R[rd] <= f(tmp, B): EXEC held ALU_LAT cycles (aluop = opcode-2) -> WB_A (sr = 010, w = 1, aluop held) -> DONE. ALU_LAT + 2 cycles.
  - 101 TMPB, tmp <= R[rs]: TLD (lt = 1, tsel = 100) -> DONE.
  - 110 TMPR0, tmp <= R0: TLD (lt = 1, tsel = 010) -> DONE.
  - 111 ACC, tmp <= tmp ^ B: EXEC ×ALU_LAT (aluop = 00) -> TLD (lt = 1, tsel = 001, aluop = 00 held) -> DONE.
- EXEC counter: loads 0 on entry, increments each cycle, exits when count = ALU_LAT-1.
- DONE: done = 1, busy = 1 for exactly one cycle, then IDLE unconditionally.
- start while busy (including DONE) is ignored and never queued. Changes to opcode/rd/rs while busy have no effect.
- Minimum accept-to-accept spacing is sequence length + 1 cycle.
- Invariants:
  - w and lt are never high in the same cycle.
  - sr and tsel are each zero or exactly one-hot.
  - w = 1 implies sr is non-zero.
  - lt = 1 implies tsel is non-zero.

Test Plan:
- Reset, then LOAD: rst_n = 0 for 2 cycles -> all outputs 0. Release, start with opcode = 000, rd = 10 -> next cycle sr = 001, w = 1, Rn = 10; following cycle done = 1; then busy = 0. With the datapath attached and in = 8'h5A, R2 = 8'h5A.
- MOV then XOR, ALU_LAT = 1: LOAD R1 = 8'h0F and R3 = 8'hF0, MOV rd = 00, rs = 01 (R0 = 8'h0F), TMPR0, XOR rd = 10, rs = 11 -> the XOR WB_A cycle shows sr = 010, w = 1, bsel = 100, and R2 = 8'hFF. XOR takes 3 cycles from accept to done.
- ALU_LAT = 3: AND with tmp = 8'h3C, rs = 01 (R1 = 8'h0F) -> aluop = 01 held for 3 EXEC cycles, w only in the 4th cycle, R[rd] = 8'h0C, done in the 5th cycle.
- ACC with rs = 00: tmp = 8'hAA -> bsel = 000, TLD has tsel = 001 and lt = 1, tmp stays 8'hAA, no w asserted.
- Start during busy: assert start continuously across a SHL -> exactly one done pulse per sequence. A new accept happens only on the IDLE cycle after done.
- Reset mid-sequence: drop rst_n during WB_T of MOV -> w falls combinationally with rst_n, the destination is unwritten, state is IDLE after release, busy = 0.
